// File: rtl/n4_b2_timer_pkg.sv
// Shared definitions for the n4_b2 interval timer: FSM encoding, counter width
// and the single-bit half-adder used to build the ripple incrementer.
package n4_b2_timer_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Returns {carry, sum} of a + b.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        logic [1:0] r;
        r[0] = a ^ b;
        r[1] = a & b;
        return r;
    endfunction

endpackage

// File: rtl/n4_b2_timer_incrementer.sv
// n4_b2_incrementer: 4-bit base-2 ripple incrementer built as a half-adder
// chain. s3_s0 = x3_x0 + cin, carry out of the top stage on cout.
module n4_b2_incrementer
    import n4_b2_timer_pkg::*;
(
    input  logic [CNT_W-1:0] x3_x0,
    input  logic             cin,
    output logic [CNT_W-1:0] s3_s0,
    output logic             cout
);

    // Ripple the carry through one half-adder per bit.
    always_comb begin
        logic       c_v;
        logic [1:0] ha_v;
        c_v   = cin;
        ha_v  = 2'b00;
        s3_s0 = {CNT_W{1'b0}};
        for (int i = 0; i < CNT_W; i++) begin
            ha_v     = half_add(x3_x0[i], c_v);
            s3_s0[i] = ha_v[0];
            c_v      = ha_v[1];
        end
        cout = c_v;
    end

endmodule

// File: rtl/n4_b2_timer.sv
// n4_b2_timer: programmable interval timer. Counts 0..limit through the ripple
// incrementer, then raises done (held until ack, or a one-cycle pulse when
// AUTO_RELOAD restarts the count).
module n4_b2_timer
    import n4_b2_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic             stop,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] inc_sum_s;
    logic             term_s;

    // The carry out is never needed: the count stops at limit_q before it can wrap.
    n4_b2_incrementer u_inc (
        .x3_x0 (count_q),
        .cin   (1'b1),
        .s3_s0 (inc_sum_s),
        .cout  ()
    );

    assign term_s = (count_q == limit_q);

    // State, count and captured-limit registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= {CNT_W{1'b0}};
            limit_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    // Next-state decode; stop outranks the terminal compare and ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (term_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (AUTO_RELOAD) begin
                    state_d = S_RUN;
                end else if (ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Count and limit updates: capture on start, increment in RUN, clear on reload.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d = limit;
                    count_d = {CNT_W{1'b0}};
                end else begin
                    count_d = count_q;
                end
            end
            S_RUN: begin
                if (!stop && !term_s) begin
                    count_d = inc_sum_s;
                end else begin
                    count_d = count_q;
                end
            end
            S_DONE: begin
                if (!stop && AUTO_RELOAD) begin
                    count_d = {CNT_W{1'b0}};
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_n4_b2_timer.sv
// Self-checking bench for n4_b2_timer: a one-shot and an auto-reload instance,
// directed scenarios followed by random traffic, all against a behavioural model.
module tb_n4_b2_timer;

    logic       clk;
    logic       rst_o, start_o, stop_o, ack_o;
    logic [3:0] limit_o;
    logic [3:0] count_o;
    logic       busy_o, done_o;
    logic       rst_a, start_a, stop_a, ack_a;
    logic [3:0] limit_a;
    logic [3:0] count_a;
    logic       busy_a, done_a;

    int total = 0;
    int bad   = 0;

    // Model per instance (0 = one-shot, 1 = auto-reload): phase flags, count, limit.
    bit m_busy [2];
    bit m_done [2];
    int m_cnt  [2];
    int m_lim  [2];

    n4_b2_timer #(.AUTO_RELOAD(1'b0)) dut_os (
        .clock (clk), .reset (rst_o), .start (start_o), .limit (limit_o),
        .stop  (stop_o), .ack (ack_o), .count (count_o), .busy (busy_o), .done (done_o)
    );

    n4_b2_timer #(.AUTO_RELOAD(1'b1)) dut_ar (
        .clock (clk), .reset (rst_a), .start (start_a), .limit (limit_a),
        .stop  (stop_a), .ack (ack_a), .count (count_a), .busy (busy_a), .done (done_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behaviour of one clock edge, written from the timer's rules.
    task automatic model_edge(input int k, input logic rst, input logic st,
                              input logic [3:0] lm, input logic sp, input logic ak);
        if (rst) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0; m_lim[k] = 0;
        end else if (m_busy[k]) begin
            if (sp) m_busy[k] = 1'b0;
            else if (m_cnt[k] == m_lim[k]) begin m_busy[k] = 1'b0; m_done[k] = 1'b1; end
            else m_cnt[k] = m_cnt[k] + 1;
        end else if (m_done[k]) begin
            if (sp) m_done[k] = 1'b0;
            else if (k == 1) begin m_done[k] = 1'b0; m_busy[k] = 1'b1; m_cnt[k] = 0; end
            else if (ak) m_done[k] = 1'b0;
        end else if (st) begin
            m_busy[k] = 1'b1; m_cnt[k] = 0; m_lim[k] = int'(lm);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, rst_o, start_o, limit_o, stop_o, ack_o);
        model_edge(1, rst_a, start_a, limit_a, stop_a, ack_a);
        #1;
        chk("os.count", {4'd0, count_o}, 8'(m_cnt[0]));
        chk("os.busy",  {7'd0, busy_o},  {7'd0, m_busy[0]});
        chk("os.done",  {7'd0, done_o},  {7'd0, m_done[0]});
        chk("ar.count", {4'd0, count_a}, 8'(m_cnt[1]));
        chk("ar.busy",  {7'd0, busy_a},  {7'd0, m_busy[1]});
        chk("ar.done",  {7'd0, done_a},  {7'd0, m_done[1]});
        if (m_busy[0] && (m_cnt[0] < m_lim[0]))
            chk("os.cout", {7'd0, dut_os.u_inc.cout}, 8'd0);
        if (m_busy[1] && (m_cnt[1] < m_lim[1]))
            chk("ar.cout", {7'd0, dut_ar.u_inc.cout}, 8'd0);
    endtask

    initial begin
        rst_o = 1'b1; start_o = 1'b0; stop_o = 1'b0; ack_o = 1'b0; limit_o = 4'd0;
        rst_a = 1'b1; start_a = 1'b0; stop_a = 1'b0; ack_a = 1'b0; limit_a = 4'd0;
        tick(); tick();
        chk("reset.count", {4'd0, count_o}, 8'd0);
        rst_o = 1'b0;

        // limit=3: four RUN cycles 0..3, done held without ack, ack returns to IDLE.
        start_o = 1'b1; limit_o = 4'd3; tick(); start_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l3.run.count", {4'd0, count_o}, 8'(i));
            chk("l3.run.busy", {7'd0, busy_o}, 8'd1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("l3.done.held", {7'd0, done_o}, 8'd1);
            tick();
        end
        ack_o = 1'b1; tick(); ack_o = 1'b0;
        chk("l3.ack.count", {4'd0, count_o}, 8'd3);
        chk("l3.ack.done", {7'd0, done_o}, 8'd0);

        // limit=0: a single RUN cycle at count 0.
        start_o = 1'b1; stop_o = 1'b1; limit_o = 4'd0; tick(); start_o = 1'b0; stop_o = 1'b0;
        chk("l0.busy", {7'd0, busy_o}, 8'd1);
        tick();
        chk("l0.done", {7'd0, done_o}, 8'd1);
        ack_o = 1'b1; tick(); ack_o = 1'b0;

        // limit=15: count runs to 15 without wrapping.
        start_o = 1'b1; limit_o = 4'd15; tick(); start_o = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("l15.done", {7'd0, done_o}, 8'd1);
        chk("l15.count", {4'd0, count_o}, 8'd15);
        ack_o = 1'b1; tick(); ack_o = 1'b0;

        // limit=9: start during RUN is ignored, stop at count 5 holds the count.
        start_o = 1'b1; limit_o = 4'd9; tick(); start_o = 1'b0;
        tick(); tick();
        start_o = 1'b1; limit_o = 4'd1; tick(); start_o = 1'b0;
        tick(); tick();
        chk("l9.count5", {4'd0, count_o}, 8'd5);
        stop_o = 1'b1; tick(); stop_o = 1'b0;
        chk("l9.stop.busy", {7'd0, busy_o}, 8'd0);
        chk("l9.stop.count", {4'd0, count_o}, 8'd5);
        tick();
        chk("l9.no.done", {7'd0, done_o}, 8'd0);

        // limit=6: reset mid-RUN, then a run with limit toggling after capture.
        start_o = 1'b1; limit_o = 4'd6; tick(); start_o = 1'b0;
        for (int i = 0; i < 4; i++) begin limit_o = 4'($urandom_range(0, 15)); tick(); end
        rst_o = 1'b1; tick(); rst_o = 1'b0;
        chk("l6.rst.count", {4'd0, count_o}, 8'd0);
        chk("l6.rst.busy", {7'd0, busy_o}, 8'd0);
        start_o = 1'b1; limit_o = 4'd6; tick(); start_o = 1'b0;
        for (int i = 0; i < 7; i++) begin limit_o = 4'($urandom_range(0, 15)); tick(); end
        chk("l6.toggle.done", {7'd0, done_o}, 8'd1);
        chk("l6.toggle.count", {4'd0, count_o}, 8'd6);
        ack_o = 1'b1; tick(); ack_o = 1'b0;

        // Auto-reload, limit=2: done pulses every fourth cycle; stop in DONE idles.
        rst_a = 1'b0;
        start_a = 1'b1; limit_a = 4'd2; tick(); start_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ar.period", {7'd0, done_a}, ((i % 4) == 3) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 4 && done_a !== 1'b1; i++) tick();
        chk("ar.reach.done", {7'd0, done_a}, 8'd1);
        stop_a = 1'b1; tick(); stop_a = 1'b0;
        chk("ar.stop.busy", {7'd0, busy_a}, 8'd0);
        chk("ar.stop.done", {7'd0, done_a}, 8'd0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            rst_o   = ($urandom_range(0, 31) == 0);
            start_o = ($urandom_range(0, 3) == 0);
            stop_o  = ($urandom_range(0, 15) == 0);
            ack_o   = ($urandom_range(0, 3) == 0);
            limit_o = 4'($urandom_range(0, 15));
            rst_a   = ($urandom_range(0, 31) == 0);
            start_a = ($urandom_range(0, 3) == 0);
            stop_a  = ($urandom_range(0, 15) == 0);
            ack_a   = ($urandom_range(0, 1) == 0);
            limit_a = 4'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
